// File: rtl/lsr_nibble_packer.sv
// Packs NUM_NIB consecutive nibbles MSB-first into one word behind valid/ready
// handshakes; a flush emits a partial word left-aligned with its nibble count.
module lsr_nibble_packer #(
    parameter  int NIB_W   = 4,
    parameter  int NUM_NIB = 4,
    localparam int OUT_W   = NIB_W * NUM_NIB,
    localparam int CNT_W   = $clog2(NUM_NIB + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NIB - 1);

    generate
        if (NUM_NIB < 2) begin : g_bad_num_nib
            $error("lsr_nibble_packer: NUM_NIB must be at least 2");
        end
    endgenerate

    // Moves the n valid low nibbles to the top of the word, zero-filling below.
    function automatic logic [OUT_W-1:0] left_align(input logic [OUT_W-1:0] a,
                                                    input logic [CNT_W-1:0] n);
        left_align = a << (NIB_W * (NUM_NIB - int'(n)));
    endfunction

    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             flush_pend;

    logic             acc_fire;
    logic             slot_free;
    logic             out_fire;
    logic [OUT_W-1:0] acc_shift;
    logic [OUT_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             load;
    logic [OUT_W-1:0] load_data;
    logic [CNT_W-1:0] load_count;
    logic [OUT_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pend_d;

    assign in_ready  = (cnt != CNT_FULL) && !flush_pend;
    assign acc_fire  = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign out_fire  = out_valid && out_ready;
    assign acc_shift = {acc[OUT_W-NIB_W-1:0], in_data};
    assign acc_nxt   = acc_fire ? acc_shift : acc;
    assign cnt_nxt   = acc_fire ? cnt + CNT_W'(1) : cnt;

    // Priority: parked full word, then pending flush, then completion, then new flush.
    always_comb begin
        load       = 1'b0;
        load_data  = '0;
        load_count = '0;
        acc_d      = acc_nxt;
        cnt_d      = cnt_nxt;
        pend_d     = flush_pend;

        if (cnt == CNT_FULL) begin
            acc_d = acc;
            cnt_d = cnt;
            if (slot_free) begin
                load       = 1'b1;
                load_data  = acc;
                load_count = CNT_FULL;
                acc_d      = '0;
                cnt_d      = '0;
            end
        end else if (flush_pend) begin
            if (slot_free) begin
                load       = 1'b1;
                load_data  = left_align(acc, cnt);
                load_count = cnt;
                acc_d      = '0;
                cnt_d      = '0;
                pend_d     = 1'b0;
            end
        end else if (acc_fire && (cnt == CNT_LAST)) begin
            if (slot_free) begin
                load       = 1'b1;
                load_data  = acc_shift;
                load_count = CNT_FULL;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                cnt_d = CNT_FULL;
            end
        end else if (flush && (cnt_nxt != '0)) begin
            if (slot_free) begin
                load       = 1'b1;
                load_data  = left_align(acc_nxt, cnt_nxt);
                load_count = cnt_nxt;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
        end else begin
            acc        <= acc_d;
            cnt        <= cnt_d;
            flush_pend <= pend_d;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_count <= load_count;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsr_nibble_packer.sv
// Bench for lsr_nibble_packer (NIB_W=4, NUM_NIB=4): scenario tasks push expected
// words into a scoreboard that an output monitor pops on every output handshake.
module tb_lsr_nibble_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_count;

    int errors = 0;
    int checks = 0;

    logic [18:0] sb[$];
    logic [18:0] mon_exp;

    lsr_nibble_packer #(.NIB_W(4), .NUM_NIB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h count=%0d, expected no word", out_data, out_count);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_count, out_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL word: got data=%h count=%0d, expected data=%h count=%0d",
                             out_data, out_count, mon_exp[15:0], mon_exp[18:16]);
                end
            end
        end
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [3:0] d, input logic fl = 1'b0);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: nibble %h not accepted, in_ready=%b expected 1", d, in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_count, in_ready} !== {1'b0, 16'h0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h count=%0d in_ready=%b, expected 0 0000 0 1",
                     out_valid, out_data, out_count, in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        sb.push_back({3'd4, 16'hABCD});
        send(4'hA); send(4'hB); send(4'hC); send(4'hD);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%b after last accept, expected 1", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: out_valid=%b second cycle, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        drain("basic");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sb.push_back({3'd4, 16'h1234});
        sb.push_back({3'd4, 16'h5678});
        for (int n = 1; n <= 8; n++) send(4'(n));
        in_valid = 1'b1;
        in_data  = 4'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 16'h1234}) begin
                errors++;
                $display("FAIL bp_hold: in_ready=%b valid=%b data=%h, expected 0 1 1234",
                         in_ready, out_valid, out_data);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_data} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL bp_release1: in_ready=%b data=%h, expected 0 1234", in_ready, out_data);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'h5678}) begin
            errors++;
            $display("FAIL bp_release2: in_ready=%b valid=%b data=%h, expected 1 1 5678",
                     in_ready, out_valid, out_data);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back({3'd4, 16'h9ABC});
        send(4'hA); send(4'hB); send(4'hC);
        drain("backpressure");
    endtask

    task automatic test_flush_partial();
        out_ready = 1'b1;
        sb.push_back({3'd2, 16'h7300});
        sb.push_back({3'd4, 16'h1234});
        send(4'h7); send(4'h3);
        pulse_flush();
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        drain("flush_partial");
    endtask

    task automatic test_flush_corners();
        out_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty: out_valid=%b, expected 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        sb.push_back({3'd3, 16'h5680});
        send(4'h5); send(4'h6); send(4'h8, 1'b1);
        drain("flush_third");
        sb.push_back({3'd4, 16'h5678});
        send(4'h5); send(4'h6); send(4'h7); send(4'h8, 1'b1);
        drain("flush_fourth");
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_fourth_extra: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_pending_flush();
        out_ready = 1'b0;
        sb.push_back({3'd4, 16'h1234});
        sb.push_back({3'd1, 16'h9000});
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        send(4'h9);
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_data} !== {1'b0, 16'h1234}) begin
                errors++;
                $display("FAIL pend_hold: in_ready=%b data=%h, expected 0 1234", in_ready, out_data);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b1, 16'h9000, 3'd1}) begin
            errors++;
            $display("FAIL pend_emit: in_ready=%b valid=%b data=%h count=%0d, expected 1 1 9000 1",
                     in_ready, out_valid, out_data, out_count);
        end
        @(posedge clk);
        #1;
        drain("pending_flush");
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b0;
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        send(4'hF); send(4'hE);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_count, in_ready} !== {1'b0, 16'h0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h count=%0d in_ready=%b, expected 0 0000 0 1",
                     out_valid, out_data, out_count, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        sb.push_back({3'd4, 16'h1234});
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        drain("reset_mid_word");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_partial();
        test_flush_corners();
        test_pending_flush();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsr_nibble_packer.md
# lsr_nibble_packer

Downstream stage of the 4-bit left shift register. It accepts the register's 4-bit parallel words as nibbles under a valid/ready handshake and packs `NUM_NIB` consecutive nibbles MSB-first into one wide word. The packed word is presented on a registered valid/ready output port. A flush input emits a partially filled word, zero-padded, together with its nibble count.

## Interface

Parameters:
- `NIB_W`, default 4: nibble width; matches the shift register's `q` width.
- `NUM_NIB`, default 4: nibbles per output word; must be ≥ 2. `OUT_W = NIB_W*NUM_NIB`. `CNT_W = clog2(NUM_NIB+1)`.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low; 0 clears all state immediately.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: packer accepts a nibble this cycle.
- `in_data`, input, `NIB_W`: nibble, normally the shift register's `q`.
- `flush`, input, 1: single-cycle request to emit the current partial word.
- `out_valid`, output, 1: `out_data` and `out_count` are valid.
- `out_ready`, input, 1: consumer takes the word this cycle.
- `out_data`, output, `OUT_W`: packed word; the first nibble received is in `[OUT_W-1:OUT_W-NIB_W]`.
- `out_count`, output, `CNT_W`: number of real nibbles in `out_data` (1..`NUM_NIB`).

## Operation

State:
- Accumulator `acc` (`OUT_W` bits) and nibble counter `cnt` (0..`NUM_NIB`).
- `flush_pend` flag.
- Output register holding `out_data`, `out_count` and `out_valid`.

Handshake and accumulation:
- Accept: `acc_fire = in_valid && in_ready`.
- On accept: `acc <= {acc[OUT_W-NIB_W-1:0], in_data}` and `cnt` increments.
- Definitions: `slot_free = !out_valid || out_ready` and `out_fire = out_valid && out_ready`.

Word completion:
- Completion occurs on an accept with `cnt == NUM_NIB-1`.
- If `slot_free`, the completed word, including the incoming nibble, loads the output register that edge with `out_count = NUM_NIB`. `cnt` goes to 0.
- Otherwise the word parks in `acc` with `cnt = NUM_NIB`.
- A parked word moves to the output register on the first edge with `slot_free`; `cnt` then goes to 0.
- `in_ready = (cnt != NUM_NIB) && !flush_pend`. It is combinational from state only and never depends on `in_valid`.

Flush:
- Flush when `cnt == 0` and no accept in the same cycle: ignored.
- Flush with `0 < cnt < NUM_NIB`: the partial word is emitted as `acc << (NIB_W*(NUM_NIB-cnt))`, i.e. left-aligned with zeros in the low nibbles, and `out_count = cnt`.
- It is emitted on the flush edge if `slot_free`. Otherwise `flush_pend` is set, and the word emits on the first `slot_free` edge, after which `flush_pend` clears.
- Flush in the same cycle as an accept: the nibble is included first, then the flush applies to the updated count.
- If that accept completes the word, the flush is a no-op and the full word is emitted normally.
- Flush while a word is parked (`cnt == NUM_NIB`): no-op.

Output register:
- Holds `out_data` and `out_count` stable while `out_valid && !out_ready`.
- Clears `out_valid` on `out_fire` unless it reloads on the same edge (back-to-back words).

## Timing

Reset (`rst` = 0, asynchronous):
- `out_valid = 0`, `out_data = 0`, `out_count = 0`.
- `cnt = 0`, `acc = 0`, `flush_pend = 0`.
- `in_ready = 1` while in reset and after release.

Latency and throughput:
- Latency: `out_valid` rises the cycle after the edge that accepts the completing nibble, or after the flush edge, when the output slot is free.
- Throughput: one nibble per cycle sustained with `out_ready` held at 1. There are no bubbles between words.

Boundary cases:
- Backpressure: at most one word in the output register plus one complete word parked in `acc`. `in_ready` falls exactly when `cnt` reaches `NUM_NIB`.
- Reset mid-operation: partial words and pending flushes are discarded, with no residue after release.

## Test plan

All scenarios use `NUM_NIB` = 4 and `NIB_W` = 4.

1. **Basic packing.** Drive nibbles A, B, C, D back-to-back with `out_ready` = 1. Required: `out_data` = 0xABCD and `out_count` = 4, with `out_valid` high for exactly one cycle, the cycle after D is accepted.
2. **Backpressure.** Hold `out_ready` = 0 and offer nibbles 1 through 9. Required: 1–8 are accepted and `in_ready` = 0 after 8, so 9 is stalled. 0x1234 is held stable. Raising `out_ready` yields 0x1234 and then 0x5678 on consecutive cycles, after which 9 is accepted.
3. **Flush partial.** Send 7, 3, then pulse `flush`. Required: `out_data` = 0x7300 and `out_count` = 2. The next nibbles 1, 2, 3, 4 yield 0x1234.
4. **Flush corner cases.**
   - Flush with `cnt` = 0: `out_valid` stays 0.
   - Flush together with the 3rd nibble, after 5, 6: `out_data` = 0x5680, `out_count` = 3.
   - Flush together with the 4th nibble: 0x5678, `out_count` = 4, and no extra word.
5. **Pending flush.** With `out_ready` = 0 and 0x1234 held, send 9 and then `flush`. Required: `in_ready` = 0 until `out_ready` rises. Output is 0x1234 followed by 0x9000 with `out_count` = 1.
6. **Reset mid-word.** After nibbles F, E, assert `rst` low asynchronously for 2 cycles. Required: outputs clear immediately and `in_ready` = 1. The subsequent 1, 2, 3, 4 yield 0x1234.
